// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multi-cycle MIPS datapath.
// Walks each instruction through FETCH/DECODE/execute/memory/write-back,
// driving the shared ALU, unified memory port and register-file controls.
// Memory accesses wait on mem_ready, with a timeout that faults into HALT.
// State encoding: 0 RST, 1 FETCH, 2 DECODE, 3 RTYPE, 4 RWB, 5 IEXEC, 6 IWB,
// 7 MADDR, 8 MREAD, 9 MWB, 10 MWRITE, 11 BRANCH, 12 JUMP, 13 JAL, 14 JR, 15 HALT.
// Optional feature macro: PERF_COUNTERS_EN (retired-instruction counter).

module multicycle_controller #(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [2:0] ALU_ADD     = 3'd0,
  parameter logic [2:0] ALU_SUB     = 3'd1,
  parameter logic [2:0] ALU_XOR     = 3'd2,
  parameter logic [2:0] ALU_SLT     = 3'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        i_or_d,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        write_enable,
  output logic        reg_dest,
  output logic        mem_to_reg,
  output logic        jal_reg_override,
  output logic        fault,
  output logic [3:0]  state,
  output logic [31:0] instr_retired
);

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_RTYPE  = 4'd3;
  localparam logic [3:0] S_RWB    = 4'd4;
  localparam logic [3:0] S_IEXEC  = 4'd5;
  localparam logic [3:0] S_IWB    = 4'd6;
  localparam logic [3:0] S_MADDR  = 4'd7;
  localparam logic [3:0] S_MREAD  = 4'd8;
  localparam logic [3:0] S_MWB    = 4'd9;
  localparam logic [3:0] S_MWRITE = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_JAL    = 4'd13;
  localparam logic [3:0] S_JR     = 4'd14;
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic [7:0] wait_cnt;
  logic       fault_q;
  logic       timed_out;
  logic       in_wait_state;

  assign state         = state_q;
  assign fault         = fault_q;
  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MREAD) || (state_q == S_MWRITE);
  // A ready arriving on the limit cycle still counts as a normal completion.
  assign timed_out     = !mem_ready && (wait_cnt == TIMEOUT_CNT);

  // Next-state selection: instruction decode plus memory handshake waits.
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_RST:    next_state = S_FETCH;
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
                else if (timed_out) next_state = S_HALT;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:     next_state = S_MADDR;
          OP_RTYPE:         next_state = (func == FN_JR) ? S_JR : S_RTYPE;
          OP_BEQ, OP_BNE:   next_state = S_BRANCH;
          OP_J:             next_state = S_JUMP;
          OP_JAL:           next_state = S_JAL;
          OP_ADDI, OP_XORI: next_state = S_IEXEC;
          default:          next_state = S_HALT;
        endcase
      end
      S_RTYPE: begin
        case (func)
          FN_ADD, FN_SUB, FN_XOR, FN_SLT: next_state = S_RWB;
          default:                        next_state = S_HALT;
        endcase
      end
      S_IEXEC:  next_state = S_IWB;
      S_MADDR:  next_state = (op == OP_SW) ? S_MWRITE : S_MREAD;
      S_MREAD:  if (mem_ready) next_state = S_MWB;
                else if (timed_out) next_state = S_HALT;
      S_MWRITE: if (mem_ready) next_state = S_FETCH;
                else if (timed_out) next_state = S_HALT;
      S_RWB, S_IWB, S_MWB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_HALT;
    endcase
  end

  // State register; reset parks the FSM in RST with every enable low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= next_state;
  end

  // Sticky fault: every route into HALT is an illegal opcode/func or a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     fault_q <= 1'b0;
    else if (next_state == S_HALT) fault_q <= 1'b1;
  end

  // Memory wait counter: restarts on each state change, counts idle wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                wait_cnt <= 8'd0;
    else if (next_state != state_q)           wait_cnt <= 8'd0;
    else if (in_wait_state && !mem_ready)     wait_cnt <= wait_cnt + 8'd1;
  end

  // Datapath controls decoded from state; FETCH and BRANCH also qualify on inputs.
  always_comb begin
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 2'd0;
    i_or_d           = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'd0;
    alu_op           = 3'd0;
    write_enable     = 1'b0;
    reg_dest         = 1'b0;
    mem_to_reg       = 1'b0;
    jal_reg_override = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_enable = 1'b1;
        alu_src_b       = 2'd1;
        alu_op          = ALU_ADD;
        ir_write        = mem_ready;
        pc_write        = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
      end
      S_RTYPE: begin
        alu_src_a = 1'b1;
        case (func)
          FN_SUB:  alu_op = ALU_SUB;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_RWB: begin
        write_enable = 1'b1;
        reg_dest     = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (op == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_IWB: write_enable = 1'b1;
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
      end
      S_MREAD: begin
        i_or_d          = 1'b1;
        mem_read_enable = 1'b1;
      end
      S_MWB: begin
        write_enable = 1'b1;
        mem_to_reg   = 1'b1;
      end
      S_MWRITE: begin
        i_or_d           = 1'b1;
        mem_write_enable = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'd1;
        pc_write  = (op == OP_BNE) ? !zero_flag : zero_flag;
      end
      S_JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_src           = 2'd2;
        pc_write         = 1'b1;
        write_enable     = 1'b1;
        jal_reg_override = 1'b1;
      end
      S_JR: begin
        pc_src   = 2'd3;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] retired_q;
  logic        retire;

  // An instruction retires on its last cycle, i.e. when it hands back to FETCH.
  assign retire = (next_state == S_FETCH) && (state_q != S_RST) && (state_q != S_FETCH);

  // Retired-instruction counter, free-running and wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_q <= 32'd0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign instr_retired = retired_q;
`else
  assign instr_retired = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed, table-driven bench for multicycle_controller.
// A program of instruction vectors with hand-computed controls is stepped
// cycle by cycle, followed by hand-written reset, timeout and halt sequences.

module tb_multicycle_controller;

  localparam logic [3:0] ST_RST    = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_RTYPE  = 4'd3;
  localparam logic [3:0] ST_RWB    = 4'd4;
  localparam logic [3:0] ST_IEXEC  = 4'd5;
  localparam logic [3:0] ST_IWB    = 4'd6;
  localparam logic [3:0] ST_MADDR  = 4'd7;
  localparam logic [3:0] ST_MREAD  = 4'd8;
  localparam logic [3:0] ST_MWB    = 4'd9;
  localparam logic [3:0] ST_MWRITE = 4'd10;
  localparam logic [3:0] ST_BRANCH = 4'd11;
  localparam logic [3:0] ST_JUMP   = 4'd12;
  localparam logic [3:0] ST_JAL    = 4'd13;
  localparam logic [3:0] ST_JR     = 4'd14;
  localparam logic [3:0] ST_HALT   = 4'd15;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        ready;
    logic [3:0]  exp_state;
    logic [17:0] exp_ctl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = 6'd0;
  logic [5:0]  func = 6'd0;
  logic        zero_flag = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, i_or_d, mem_read_enable, mem_write_enable;
  logic        alu_src_a, write_enable, reg_dest, mem_to_reg, jal_reg_override, fault;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  int compare_count = 0;
  int fail_count = 0;
  vec_t vecs[$];

  logic [17:0] e_fetch_go, e_fetch_wait, e_decode, e_rt_add, e_rt_sub, e_rt_slt, e_rwb;
  logic [17:0] e_iex_add, e_iex_xor, e_iwb, e_maddr, e_mread, e_mwb, e_mwrite;
  logic [17:0] e_jump, e_jal, e_jr, e_br_taken, e_br_not, e_halt;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .write_enable(write_enable), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
    .jal_reg_override(jal_reg_override), .fault(fault), .state(state),
    .instr_retired(instr_retired)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Packs expected controls: irw,pcw,pc_src,i_or_d,mrd,mwr,src_a,src_b,alu_op,we,rdst,m2r,jal,fault.
  function automatic logic [17:0] c(input int irw, input int pcw, input int pcs, input int iod,
                                     input int mrd, input int mwr, input int sa, input int sb,
                                     input int aop, input int we, input int rd, input int m2r,
                                     input int jal, input int flt);
    return {1'(irw), 1'(pcw), 2'(pcs), 1'(iod), 1'(mrd), 1'(mwr), 1'(sa), 2'(sb), 3'(aop),
            1'(we), 1'(rd), 1'(m2r), 1'(jal), 1'(flt)};
  endfunction

  function automatic vec_t v(input string name, input logic [5:0] vop, input logic [5:0] vfn,
                             input logic z, input logic r, input logic [3:0] st,
                             input logic [17:0] ctl);
    vec_t x;
    x.name = name; x.op = vop; x.func = vfn; x.zero = z; x.ready = r;
    x.exp_state = st; x.exp_ctl = ctl;
    return x;
  endfunction

  task automatic applyStimulus(input logic [5:0] a_op, input logic [5:0] a_fn,
                               input logic a_z, input logic a_r);
    @(negedge clk);
    op = a_op; func = a_fn; zero_flag = a_z; mem_ready = a_r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_state,
                             input logic [17:0] exp_ctl);
    logic [17:0] act;
    act = {ir_write, pc_write, pc_src, i_or_d, mem_read_enable, mem_write_enable, alu_src_a,
           alu_src_b, alu_op, write_enable, reg_dest, mem_to_reg, jal_reg_override, fault};
    compare_count++;
    if (state !== exp_state) begin
      fail_count++;
      $display("[TB] FAIL %s state: got %0d expected %0d", name, state, exp_state);
    end
    compare_count++;
    if (act !== exp_ctl) begin
      fail_count++;
      $display("[TB] FAIL %s controls: got %05h expected %05h", name, act, exp_ctl);
    end
  endtask

  task automatic checkCounter(input string name, input logic [31:0] expected);
    compare_count++;
    if (instr_retired !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s instr_retired: got %0d expected %0d", name, instr_retired, expected);
    end
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].op, vecs[i].func, vecs[i].zero, vecs[i].ready);
      checkOutput($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].exp_state, vecs[i].exp_ctl);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    e_fetch_go   = c(1,1,0,0,1,0,0,1,0,0,0,0,0,0);
    e_fetch_wait = c(0,0,0,0,1,0,0,1,0,0,0,0,0,0);
    e_decode     = c(0,0,0,0,0,0,0,3,0,0,0,0,0,0);
    e_rt_add     = c(0,0,0,0,0,0,1,0,0,0,0,0,0,0);
    e_rt_sub     = c(0,0,0,0,0,0,1,0,1,0,0,0,0,0);
    e_rt_slt     = c(0,0,0,0,0,0,1,0,3,0,0,0,0,0);
    e_rwb        = c(0,0,0,0,0,0,0,0,0,1,1,0,0,0);
    e_iex_add    = c(0,0,0,0,0,0,1,2,0,0,0,0,0,0);
    e_iex_xor    = c(0,0,0,0,0,0,1,2,2,0,0,0,0,0);
    e_iwb        = c(0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    e_maddr      = c(0,0,0,0,0,0,1,2,0,0,0,0,0,0);
    e_mread      = c(0,0,0,1,1,0,0,0,0,0,0,0,0,0);
    e_mwb        = c(0,0,0,0,0,0,0,0,0,1,0,1,0,0);
    e_mwrite     = c(0,0,0,1,0,1,0,0,0,0,0,0,0,0);
    e_jump       = c(0,1,2,0,0,0,0,0,0,0,0,0,0,0);
    e_jal        = c(0,1,2,0,0,0,0,0,0,1,0,0,1,0);
    e_jr         = c(0,1,3,0,0,0,0,0,0,0,0,0,0,0);
    e_br_taken   = c(0,1,1,0,0,0,1,0,1,0,0,0,0,0);
    e_br_not     = c(0,0,1,0,0,0,1,0,1,0,0,0,0,0);
    e_halt       = c(0,0,0,0,0,0,0,0,0,0,0,0,0,1);

    // 0..17: ADD, ADDI, SW, J, JAL with immediate memory ready
    vecs.push_back(v("add", 6'h00, 6'h20, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("add", 6'h00, 6'h20, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("add", 6'h00, 6'h20, 0, 1, ST_RTYPE,  e_rt_add));
    vecs.push_back(v("add", 6'h00, 6'h20, 0, 1, ST_RWB,    e_rwb));
    vecs.push_back(v("addi", 6'h08, 6'h00, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("addi", 6'h08, 6'h00, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("addi", 6'h08, 6'h00, 0, 1, ST_IEXEC,  e_iex_add));
    vecs.push_back(v("addi", 6'h08, 6'h00, 0, 1, ST_IWB,    e_iwb));
    vecs.push_back(v("sw", 6'h2B, 6'h00, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("sw", 6'h2B, 6'h00, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("sw", 6'h2B, 6'h00, 0, 1, ST_MADDR,  e_maddr));
    vecs.push_back(v("sw", 6'h2B, 6'h00, 0, 1, ST_MWRITE, e_mwrite));
    vecs.push_back(v("j", 6'h02, 6'h00, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("j", 6'h02, 6'h00, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("j", 6'h02, 6'h00, 0, 1, ST_JUMP,   e_jump));
    vecs.push_back(v("jal", 6'h03, 6'h00, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("jal", 6'h03, 6'h00, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("jal", 6'h03, 6'h00, 0, 1, ST_JAL,    e_jal));
    // 18..38: SUB, XORI, BEQ taken, BNE not taken, JR, SLT
    vecs.push_back(v("sub", 6'h00, 6'h22, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("sub", 6'h00, 6'h22, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("sub", 6'h00, 6'h22, 0, 1, ST_RTYPE,  e_rt_sub));
    vecs.push_back(v("sub", 6'h00, 6'h22, 0, 1, ST_RWB,    e_rwb));
    vecs.push_back(v("xori", 6'h0E, 6'h00, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("xori", 6'h0E, 6'h00, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("xori", 6'h0E, 6'h00, 0, 1, ST_IEXEC,  e_iex_xor));
    vecs.push_back(v("xori", 6'h0E, 6'h00, 0, 1, ST_IWB,    e_iwb));
    vecs.push_back(v("beq", 6'h04, 6'h00, 1, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("beq", 6'h04, 6'h00, 1, 1, ST_DECODE, e_decode));
    vecs.push_back(v("beq", 6'h04, 6'h00, 1, 1, ST_BRANCH, e_br_taken));
    vecs.push_back(v("bne", 6'h05, 6'h00, 1, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("bne", 6'h05, 6'h00, 1, 1, ST_DECODE, e_decode));
    vecs.push_back(v("bne", 6'h05, 6'h00, 1, 1, ST_BRANCH, e_br_not));
    vecs.push_back(v("jr", 6'h00, 6'h08, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("jr", 6'h00, 6'h08, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("jr", 6'h00, 6'h08, 0, 1, ST_JR,     e_jr));
    vecs.push_back(v("slt", 6'h00, 6'h2A, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("slt", 6'h00, 6'h2A, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("slt", 6'h00, 6'h2A, 0, 1, ST_RTYPE,  e_rt_slt));
    vecs.push_back(v("slt", 6'h00, 6'h2A, 0, 1, ST_RWB,    e_rwb));
    // 39..49: LW with ready held off 3 cycles in FETCH and in MREAD
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_FETCH,  e_fetch_wait));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_FETCH,  e_fetch_wait));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_FETCH,  e_fetch_wait));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_DECODE, e_decode));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_MADDR,  e_maddr));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_MREAD,  e_mread));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_MREAD,  e_mread));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 0, ST_MREAD,  e_mread));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 1, ST_MREAD,  e_mread));
    vecs.push_back(v("lw", 6'h23, 6'h00, 0, 1, ST_MWB,    e_mwb));
    // 50..54: illegal opcode 0x3F halts with fault and stays put
    vecs.push_back(v("illegal", 6'h3F, 6'h00, 0, 1, ST_FETCH,  e_fetch_go));
    vecs.push_back(v("illegal", 6'h3F, 6'h00, 0, 1, ST_DECODE, e_decode));
    vecs.push_back(v("illegal", 6'h3F, 6'h00, 0, 1, ST_HALT,   e_halt));
    vecs.push_back(v("illegal", 6'h3F, 6'h00, 1, 1, ST_HALT,   e_halt));
    vecs.push_back(v("illegal", 6'h00, 6'h20, 0, 1, ST_HALT,   e_halt));

    // Reset state
    #12;
    checkOutput("reset", ST_RST, 18'd0);
    checkCounter("reset", 32'd0);
    doReset();

    // Main program; five retirements after JAL
    runVectors(0, 17);
    @(posedge clk); #1;
`ifdef PERF_COUNTERS_EN
    checkCounter("five_instr", 32'd5);
`else
    checkCounter("five_instr", 32'd0);
`endif
    runVectors(18, 54);
`ifdef PERF_COUNTERS_EN
    checkCounter("program_end", 32'd12);
`else
    checkCounter("program_end", 32'd0);
`endif

    // Fetch timeout: 16 idle cycles in FETCH then HALT with fault
    doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(6'h00, 6'h20, 0, 0);
      checkOutput($sformatf("timeout_wait%0d", k), ST_FETCH, e_fetch_wait);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'h00, 6'h20, 0, 1);
      checkOutput($sformatf("timeout_halt%0d", k), ST_HALT, e_halt);
    end

    // Ready on the limit cycle still wins
    doReset();
    for (int k = 0; k < 15; k++) applyStimulus(6'h00, 6'h20, 0, 0);
    applyStimulus(6'h00, 6'h20, 0, 1);
    checkOutput("ready_at_limit", ST_FETCH, e_fetch_go);
    applyStimulus(6'h00, 6'h20, 0, 1);
    checkOutput("ready_at_limit_next", ST_DECODE, e_decode);

    // Illegal R-type func halts from RTYPE
    doReset();
    applyStimulus(6'h00, 6'h3F, 0, 1);
    applyStimulus(6'h00, 6'h3F, 0, 1);
    applyStimulus(6'h00, 6'h3F, 0, 1);
    checkOutput("bad_func_rtype", ST_RTYPE, e_rt_add);
    applyStimulus(6'h00, 6'h3F, 0, 1);
    checkOutput("bad_func_halt", ST_HALT, e_halt);

    // Reset in the middle of MREAD aborts immediately
    doReset();
    applyStimulus(6'h23, 6'h00, 0, 1);
    applyStimulus(6'h23, 6'h00, 0, 1);
    applyStimulus(6'h23, 6'h00, 0, 0);
    applyStimulus(6'h23, 6'h00, 0, 0);
    checkOutput("mid_mread", ST_MREAD, e_mread);
    reset = 1'b1;
    #1;
    checkOutput("mid_mread_reset", ST_RST, 18'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_released", ST_RST, 18'd0);
    @(posedge clk); #1;
    checkOutput("after_release", ST_FETCH, e_fetch_wait);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
